// File: rtl/sd_dat_rx.sv
// SD host DAT receive deserializer: start-bit detect, nibble-wise word assembly,
// per-line CRC16 check and end-bit check for one data block.
module sd_dat_rx #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LINES       = 4,
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [LINES-1:0]  dat_in,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              busy,
  output logic              complete,
  output logic              crc_error,
  output logic              end_error
);

  localparam int unsigned NIBS  = DATA_W / LINES;
  localparam int unsigned BEATS = BLOCK_BYTES * 8 / LINES;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam int unsigned NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [NIB_W-1:0] LAST_NIB  = NIB_W'(NIBS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StData,
    StCrc,
    StEnd,
    StDone
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [NIB_W-1:0]  r_nib;
  logic [3:0]        r_crc_cnt;
  logic [15:0]       r_crc [LINES];
  logic [DATA_W-1:0] r_word;
  logic              r_word_valid;
  logic              r_busy;
  logic              r_complete;
  logic              r_crc_error;
  logic              r_end_error;

  logic [DATA_W-1:0] w_shift_next;
  logic [LINES-1:0]  w_crc_top;

  assign w_shift_next = (r_shift << LINES) | DATA_W'(dat_in);

  // During CRC beats each line's register is shifted out MSB first.
  always_comb begin
    w_crc_top = '0;
    for (int i = 0; i < int'(LINES); i++) begin
      w_crc_top[i] = r_crc[i][15];
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_nib        <= '0;
      r_crc_cnt    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_complete   <= 1'b0;
      r_crc_error  <= 1'b0;
      r_end_error  <= 1'b0;
      for (int i = 0; i < int'(LINES); i++) begin
        r_crc[i] <= '0;
      end
    end else begin
      r_word_valid <= 1'b0;
      r_complete   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (enable) begin
            r_state     <= StWaitStart;
            r_busy      <= 1'b1;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_nib       <= '0;
            r_crc_cnt   <= '0;
            r_crc_error <= 1'b0;
            r_end_error <= 1'b0;
            for (int i = 0; i < int'(LINES); i++) begin
              r_crc[i] <= '0;
            end
          end
        end
        StWaitStart: begin
          if (!enable) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (dat_in == '0) begin
            r_state <= StData;
          end
        end
        StData: begin
          if (!enable) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_shift <= w_shift_next;
            for (int i = 0; i < int'(LINES); i++) begin
              r_crc[i] <= {r_crc[i][14:0], 1'b0} ^
                          ((r_crc[i][15] ^ dat_in[i]) ? 16'h1021 : 16'h0000);
            end
            if (r_nib == LAST_NIB) begin
              r_nib        <= '0;
              r_word       <= w_shift_next;
              r_word_valid <= 1'b1;
            end else begin
              r_nib <= r_nib + NIB_W'(1);
            end
            if (r_cnt == LAST_BEAT) begin
              r_state   <= StCrc;
              r_crc_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        StCrc: begin
          if (!enable) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            if (dat_in != w_crc_top) begin
              r_crc_error <= 1'b1;
            end
            for (int i = 0; i < int'(LINES); i++) begin
              r_crc[i] <= {r_crc[i][14:0], 1'b0};
            end
            if (r_crc_cnt == 4'd15) begin
              r_state <= StEnd;
            end else begin
              r_crc_cnt <= r_crc_cnt + 4'd1;
            end
          end
        end
        StEnd: begin
          if (!enable) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            if (dat_in != '1) begin
              r_end_error <= 1'b1;
            end
            r_state <= StDone;
          end
        end
        StDone: begin
          r_complete <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_word_valid;
  assign busy       = r_busy;
  assign complete   = r_complete;
  assign crc_error  = r_crc_error;
  assign end_error  = r_end_error;

endmodule

// File: tb/tb_sd_dat_rx.sv
// Directed bench for sd_dat_rx with an 8-byte block: table of block vectors plus
// abort/re-arm and reset-mid-CRC sequences.
module tb_sd_dat_rx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  dat_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        complete;
  logic        crc_error;
  logic        end_error;

  sd_dat_rx #(
    .DATA_W     (32),
    .LINES      (4),
    .BLOCK_BYTES(8)
  ) dut (
    .sd_clock  (clk),
    .reset     (reset),
    .enable    (enable),
    .dat_in    (dat_in),
    .word_out  (word_out),
    .word_valid(word_valid),
    .busy      (busy),
    .complete  (complete),
    .crc_error (crc_error),
    .end_error (end_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;      // nibble 0 in [63:60]
    int          flip_line; // -1: no CRC corruption
    int          flip_beat;
    logic [3:0]  end_nib;
    logic        exp_crc;
    logic        exp_end;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_errors = 0;
  int          e = 0;
  int          s_edge = 0;
  int          nv = 0;
  int          ncomp = 0;
  int          cpos = 0;
  int          last_valid = 0;
  int          n_consec = 0;
  int          vpos [4];
  logic [31:0] words [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    if (word_valid) begin
      if (nv < 4) begin
        words[nv] = word_out;
        vpos[nv]  = e - s_edge;
      end
      nv++;
      if (last_valid == 1) n_consec++;
    end
    last_valid = int'(word_valid);
    if (complete) begin
      ncomp++;
      cpos = e - s_edge;
    end
  endtask

  function automatic logic [15:0] crc_line(input logic [63:0] data, input int line);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int j = 0; j < 16; j++) begin
      fb = c[15] ^ data[60 - 4 * j + line];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic start_block();
    enable = 1'b1;
    dat_in = 4'hF;
    tick();
    dat_in = 4'h0;
    tick();
    s_edge   = e;
    nv       = 0;
    ncomp    = 0;
    n_consec = 0;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] crcs [4];
    logic [3:0]  b;
    v = vecs[idx];
    enable = 1'b1;
    dat_in = 4'hF;
    tick();
    chk($sformatf("v%0d busy after arm", idx), 64'(busy), 64'd1);
    chk($sformatf("v%0d flags cleared on arm", idx), 64'({crc_error, end_error}), 64'd0);
    dat_in = 4'h0;
    tick();
    s_edge   = e;
    nv       = 0;
    ncomp    = 0;
    n_consec = 0;
    for (int j = 0; j < 16; j++) begin
      dat_in = v.data[63 - 4 * j -: 4];
      tick();
    end
    for (int i = 0; i < 4; i++) crcs[i] = crc_line(v.data, i);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        b[i] = crcs[i][15 - k] ^ ((i == v.flip_line) && (k == v.flip_beat));
      end
      dat_in = b;
      tick();
    end
    dat_in = v.end_nib;
    tick();
    dat_in = 4'hF;
    enable = 1'b0;
    tick();
    chk($sformatf("v%0d complete count", idx), 64'(ncomp), 64'd1);
    chk($sformatf("v%0d complete edge", idx), 64'(cpos), 64'd34);
    chk($sformatf("v%0d valid count", idx), 64'(nv), 64'd2);
    chk($sformatf("v%0d valid0 edge", idx), 64'(vpos[0]), 64'd8);
    chk($sformatf("v%0d valid1 edge", idx), 64'(vpos[1]), 64'd16);
    chk($sformatf("v%0d word0", idx), 64'(words[0]), 64'(v.data[63:32]));
    chk($sformatf("v%0d word1", idx), 64'(words[1]), 64'(v.data[31:0]));
    chk($sformatf("v%0d valid consecutive", idx), 64'(n_consec), 64'd0);
    chk($sformatf("v%0d crc_error", idx), 64'(crc_error), 64'(v.exp_crc));
    chk($sformatf("v%0d end_error", idx), 64'(end_error), 64'(v.exp_end));
    chk($sformatf("v%0d busy at complete", idx), 64'(busy), 64'd0);
    tick();
    chk($sformatf("v%0d complete one cycle", idx), 64'(complete), 64'd0);
    chk($sformatf("v%0d flags held", idx), 64'({crc_error, end_error}),
        64'({v.exp_crc, v.exp_end}));
  endtask

  initial begin
    vecs[0] = '{data: 64'h0, flip_line: -1, flip_beat: 0, end_nib: 4'hF,
                exp_crc: 1'b0, exp_end: 1'b0};
    vecs[1] = '{data: 64'h1234_5678_9ABC_DEF0, flip_line: -1, flip_beat: 0, end_nib: 4'hF,
                exp_crc: 1'b0, exp_end: 1'b0};
    vecs[2] = '{data: 64'h0, flip_line: 2, flip_beat: 5, end_nib: 4'hF,
                exp_crc: 1'b1, exp_end: 1'b0};
    vecs[3] = '{data: 64'h0, flip_line: -1, flip_beat: 0, end_nib: 4'hE,
                exp_crc: 1'b0, exp_end: 1'b1};
    vecs[4] = '{data: 64'hFFFF_0000_A5A5_5A5A, flip_line: 0, flip_beat: 15, end_nib: 4'h7,
                exp_crc: 1'b1, exp_end: 1'b1};
    vecs[5] = '{data: 64'hDEAD_BEEF_CAFE_F00D, flip_line: -1, flip_beat: 0, end_nib: 4'hF,
                exp_crc: 1'b0, exp_end: 1'b0};

    reset  = 1'b1;
    enable = 1'b0;
    dat_in = 4'hF;
    tick();
    tick();
    chk("reset word_out", 64'(word_out), 64'd0);
    chk("reset ctrl outputs", 64'({word_valid, busy, complete, crc_error, end_error}), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Abort after 5 data beats, then a clean block must still work.
    start_block();
    for (int j = 0; j < 5; j++) begin
      dat_in = 4'(j + 1);
      tick();
    end
    enable = 1'b0;
    dat_in = 4'hF;
    tick();
    chk("abort busy", 64'(busy), 64'd0);
    for (int j = 0; j < 40; j++) tick();
    chk("abort valid count", 64'(nv), 64'd0);
    chk("abort complete count", 64'(ncomp), 64'd0);
    chk("abort busy later", 64'(busy), 64'd0);
    run_vec(0);

    // Reset in the middle of the CRC field with bad CRC bits already seen.
    start_block();
    for (int j = 0; j < 16; j++) begin
      dat_in = 4'hA;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      dat_in = 4'h5;
      tick();
    end
    chk("midcrc crc_error set", 64'(crc_error), 64'd1);
    chk("midcrc word_out", 64'(word_out), 64'hAAAA_AAAA);
    reset = 1'b1;
    tick();
    chk("midcrc reset word_out", 64'(word_out), 64'd0);
    chk("midcrc reset ctrl", 64'({word_valid, busy, complete, crc_error, end_error}), 64'd0);
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    chk("midcrc idle busy", 64'(busy), 64'd0);
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
